// File: rtl/miner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : miner_pkg
// Purpose  : Shared types and width defaults for the hash core dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package miner_pkg;

  localparam int DEF_HASH_W  = 256;
  localparam int DEF_NONCE_W = 32;
  localparam int RESULT_W    = DEF_HASH_W + DEF_NONCE_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/hash_core_dispatcher_winner_select.sv
`default_nettype none
// ============================================================================
// Module   : core_winner_select
// Purpose  : Lowest-index priority encoder over core_done & core_found.
// Revision : 1.0 - initial release
// ============================================================================
module core_winner_select #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] done,
  input  logic [NUM_CORES-1:0] found,
  output logic                 any_found,
  output logic [IDX_W-1:0]     idx
);

  logic [NUM_CORES-1:0] hits;
  assign hits = done & found;

  // Scan from the top down so the lowest reporting core overwrites last.
  always_comb begin
    any_found = |hits;
    idx       = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hits[i]) idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hash_core_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : hash_core_dispatcher
// Purpose  : Splits a job's nonce space over NUM_CORES hash cores, launches
//            them together, picks the lowest-index winner, quits the rest
//            and returns a single result to the controller.
// Revision : 1.0 - initial release
// ============================================================================
module hash_core_dispatcher
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = DEF_NONCE_W,
  parameter int HASH_W    = DEF_HASH_W
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                begin_hash,
  input  logic                                quit_hash,
  input  logic [NONCE_W-1:0]                  base_nonce,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES*NONCE_W-1:0]        core_nonce_base,
  output logic [NUM_CORES-1:0]                core_quit,
  input  logic [NUM_CORES-1:0]                core_done,
  input  logic [NUM_CORES-1:0]                core_found,
  input  logic [NUM_CORES*(HASH_W+NONCE_W)-1:0] core_result,
  output logic                                hash_done,
  output logic                                valid_hash_flag,
  output logic [HASH_W+NONCE_W-1:0]           valid_hash,
  output logic                                busy
);

  localparam int RES_W = HASH_W + NONCE_W;
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // Each core owns 2^SHIFT consecutive nonces.
  localparam int SHIFT = NONCE_W - $clog2(NUM_CORES);
  localparam logic [NUM_CORES-1:0] ALL_DONE = '1;

  disp_state_t                  state;
  logic [NUM_CORES-1:0]         done_mask;
  logic                         winner;
  logic                         aborted;
  logic [NUM_CORES-1:0]         mask_next;
  logic [NUM_CORES*NONCE_W-1:0] next_bases;
  logic                         any_found;
  logic [IDX_W-1:0]             win_idx;
  logic [RES_W-1:0]             win_result;

  assign mask_next  = done_mask | core_done;
  assign win_result = core_result[win_idx*RES_W +: RES_W];

  // Per-core start nonces; the addition wraps modulo 2^NONCE_W by width.
  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
      assign next_bases[i*NONCE_W +: NONCE_W] = base_nonce + (NONCE_W'(i) << SHIFT);
    end
  endgenerate

  core_winner_select #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_winner_select (
    .done      (core_done),
    .found     (core_found),
    .any_found (any_found),
    .idx       (win_idx)
  );

  // Dispatcher FSM with all controller and core-facing outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= ST_IDLE;
      done_mask       <= '0;
      winner          <= 1'b0;
      aborted         <= 1'b0;
      core_start      <= '0;
      core_nonce_base <= '0;
      core_quit       <= '0;
      hash_done       <= 1'b0;
      valid_hash_flag <= 1'b0;
      valid_hash      <= '0;
      busy            <= 1'b0;
    end else begin
      core_start      <= '0;
      hash_done       <= 1'b0;
      valid_hash_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (begin_hash) begin
            core_nonce_base <= next_bases;
            done_mask       <= '0;
            winner          <= 1'b0;
            aborted         <= 1'b0;
            core_start      <= ALL_DONE;
            busy            <= 1'b1;
            state           <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          done_mask <= mask_next;
          if (quit_hash) begin
            aborted   <= 1'b1;
            core_quit <= ~mask_next;
            state     <= ST_DRAIN;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          done_mask <= mask_next;
          if (any_found) begin
            // A find beats a same-cycle quit: the job completes normally.
            valid_hash <= win_result;
            winner     <= 1'b1;
            if (mask_next == ALL_DONE) begin
              hash_done       <= 1'b1;
              valid_hash_flag <= 1'b1;
              state           <= ST_REPORT;
            end else begin
              core_quit <= ~mask_next;
              state     <= ST_DRAIN;
            end
          end else if (quit_hash) begin
            aborted   <= 1'b1;
            core_quit <= ~mask_next;
            state     <= ST_DRAIN;
          end else if (mask_next == ALL_DONE) begin
            hash_done       <= 1'b1;
            valid_hash_flag <= winner;
            state           <= ST_REPORT;
          end
        end
        ST_DRAIN: begin
          // Late finds are dropped; only completion is tracked here.
          done_mask <= mask_next;
          core_quit <= ~mask_next;
          if (mask_next == ALL_DONE) begin
            if (aborted) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              hash_done       <= 1'b1;
              valid_hash_flag <= winner;
              state           <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_core_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_core_dispatcher
// Purpose  : Self-checking bench for hash_core_dispatcher (4 cores).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_core_dispatcher;

  localparam int NC = 4;
  localparam int NW = 32;
  localparam int HW = 256;
  localparam int RW = HW + NW;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             begin_hash = 1'b0;
  logic             quit_hash = 1'b0;
  logic [NW-1:0]    base_nonce = '0;
  logic [NC-1:0]    core_start;
  logic [NC*NW-1:0] core_nonce_base;
  logic [NC-1:0]    core_quit;
  logic [NC-1:0]    core_done = '0;
  logic [NC-1:0]    core_found = '0;
  logic [NC*RW-1:0] core_result = '0;
  logic             hash_done;
  logic             valid_hash_flag;
  logic [RW-1:0]    valid_hash;
  logic             busy;

  hash_core_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .begin_hash      (begin_hash),
    .quit_hash       (quit_hash),
    .base_nonce      (base_nonce),
    .core_start      (core_start),
    .core_nonce_base (core_nonce_base),
    .core_quit       (core_quit),
    .core_done       (core_done),
    .core_found      (core_found),
    .core_result     (core_result),
    .hash_done       (hash_done),
    .valid_hash_flag (valid_hash_flag),
    .valid_hash      (valid_hash),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  typedef struct {
    logic          flag;
    logic [RW-1:0] res;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NW-1:0]    base;
    logic [NC*NW-1:0] bases;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every hash_done pulse must match the oldest expected result.
  always @(negedge clk) begin : sb_check
    exp_t e;
    if (n_rst && hash_done) begin
      done_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got hash_done=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        chk("sb_flag", {319'd0, valid_hash_flag}, {319'd0, e.flag});
        chk("sb_hash", {32'd0, valid_hash}, {32'd0, e.res});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic f, input logic [RW-1:0] r);
    exp_t e;
    e.flag = f;
    e.res  = r;
    sb.push_back(e);
  endtask

  task automatic set_res(input int i, input logic [RW-1:0] r);
    core_result[i*RW +: RW] = r;
  endtask

  // Issue a job and check the launch cycle; returns with the DUT in RUN.
  task automatic launch(input logic [NW-1:0] b, input logic [NC*NW-1:0] exp_bases);
    base_nonce = b;
    begin_hash = 1'b1;
    step();
    begin_hash = 1'b0;
    chk("launch_start", core_start, 4'b1111);
    chk("launch_busy", busy, 1'b1);
    chk("launch_bases", core_nonce_base, exp_bases);
    step();
    chk("start_one_cycle", core_start, 4'b0000);
    chk("run_busy", busy, 1'b1);
  endtask

  localparam logic [RW-1:0] R2  = {256'hC0FFEE02_11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE, 32'h7000_0123};
  localparam logic [RW-1:0] RX  = {256'hBAD0_0000, 32'hF000_0055};
  localparam logic [RW-1:0] R1  = {256'h1111_0001_0000_0000_0000_0000_0000_0001, 32'h4000_0042};
  localparam logic [RW-1:0] R3  = {256'h3333_0003, 32'hC000_0077};
  localparam logic [RW-1:0] R0  = {256'hA5A5_0000, 32'h1234_5679};
  localparam logic [RW-1:0] R5  = {256'h5555_5555, 32'h8000_0009};

  logic [RW-1:0] prev_hash;
  int            cnt;

  initial begin
    tbl[0] = '{32'hF000_0000, {32'hB000_0000, 32'h7000_0000, 32'h3000_0000, 32'hF000_0000}};
    tbl[1] = '{32'h0000_0000, {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}};
    tbl[2] = '{32'hFFFF_FFFF, {32'hBFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'hFFFF_FFFF}};
    tbl[3] = '{32'h1234_5678, {32'hD234_5678, 32'h9234_5678, 32'h5234_5678, 32'h1234_5678}};

    // Reset state
    step();
    step();
    chk("rst_start", core_start, 4'b0000);
    chk("rst_quit", core_quit, 4'b0000);
    chk("rst_bases", core_nonce_base, 128'd0);
    chk("rst_hash", valid_hash, 288'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", hash_done, 1'b0);
    n_rst = 1'b1;
    step();

    // Table: partitioning incl. wrap-around, all cores done without a find
    prev_hash = '0;
    for (int v = 0; v < 4; v++) begin
      launch(tbl[v].base, tbl[v].bases);
      push(1'b0, prev_hash);
      core_done = 4'b1111;
      step();
      core_done = 4'b0000;
      chk("tbl_hash_done", hash_done, 1'b1);
      chk("tbl_flag", valid_hash_flag, 1'b0);
      chk("tbl_busy_report", busy, 1'b1);
      step();
      chk("tbl_done_pulse", hash_done, 1'b0);
      chk("tbl_busy_fall", busy, 1'b0);
    end

    // Core 2 finds; a late find from core 0 during drain is discarded
    launch(tbl[0].base, tbl[0].bases);
    core_done = 4'b0100;
    core_found = 4'b0100;
    set_res(2, R2);
    push(1'b1, R2);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    chk("c2_capture", valid_hash, R2);
    chk("c2_quit", core_quit, 4'b1011);
    chk("c2_no_done_yet", hash_done, 1'b0);
    core_done = 4'b1011;
    core_found = 4'b0001;
    set_res(0, RX);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    chk("c2_hash_done", hash_done, 1'b1);
    chk("c2_flag", valid_hash_flag, 1'b1);
    chk("c2_nonce", valid_hash[NW-1:0], 32'h7000_0123);
    chk("c2_quit_clear", core_quit, 4'b0000);
    step();
    chk("c2_idle", busy, 1'b0);

    // Cores 1 and 3 find together: core 1 wins
    launch(tbl[1].base, tbl[1].bases);
    core_done = 4'b1010;
    core_found = 4'b1010;
    set_res(1, R1);
    set_res(3, R3);
    push(1'b1, R1);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    chk("c13_capture", valid_hash, R1);
    chk("c13_quit", core_quit, 4'b0101);
    core_done = 4'b0101;
    core_found = 4'b0100;
    set_res(2, R3);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    chk("c13_hash_done", hash_done, 1'b1);
    chk("c13_kept", valid_hash, R1);
    step();

    // No find: flag low, previous result held
    launch(tbl[3].base, tbl[3].bases);
    core_done = 4'b0011;
    step();
    core_done = 4'b1100;
    push(1'b0, R1);
    step();
    core_done = 4'b0000;
    chk("nf_hash_done", hash_done, 1'b1);
    chk("nf_flag", valid_hash_flag, 1'b0);
    chk("nf_held", valid_hash, R1);
    step();

    // Abort with cores 0-1 done; begin during drain is ignored
    launch(tbl[2].base, tbl[2].bases);
    core_done = 4'b0011;
    step();
    core_done = 4'b0000;
    quit_hash = 1'b1;
    step();
    quit_hash = 1'b0;
    chk("ab_quit", core_quit, 4'b1100);
    chk("ab_busy", busy, 1'b1);
    base_nonce = 32'hDEAD_BEEF;
    begin_hash = 1'b1;
    step();
    begin_hash = 1'b0;
    chk("ab_begin_ignored", core_start, 4'b0000);
    chk("ab_bases_held", core_nonce_base, tbl[2].bases);
    chk("ab_quit_held", core_quit, 4'b1100);
    cnt = done_seen;
    core_done = 4'b1100;
    step();
    core_done = 4'b0000;
    chk("ab_idle", busy, 1'b0);
    chk("ab_quit_clear", core_quit, 4'b0000);
    chk("ab_no_hash_done", hash_done, 1'b0);
    step();
    step();
    chk("ab_no_pulse", done_seen, cnt);
    chk("ab_still_idle", busy, 1'b0);

    // Find and quit in the same cycle: find wins
    launch(tbl[3].base, tbl[3].bases);
    core_done = 4'b0001;
    core_found = 4'b0001;
    quit_hash = 1'b1;
    set_res(0, R0);
    push(1'b1, R0);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    quit_hash = 1'b0;
    chk("fq_capture", valid_hash, R0);
    chk("fq_quit", core_quit, 4'b1110);
    core_done = 4'b1110;
    step();
    core_done = 4'b0000;
    chk("fq_hash_done", hash_done, 1'b1);
    chk("fq_flag", valid_hash_flag, 1'b1);
    step();

    // Reset mid-run, then a normal job
    launch(tbl[0].base, tbl[0].bases);
    core_done = 4'b0001;
    step();
    core_done = 4'b0000;
    n_rst = 1'b0;
    #1;
    chk("mr_bases", core_nonce_base, 128'd0);
    chk("mr_hash", valid_hash, 288'd0);
    chk("mr_quit", core_quit, 4'b0000);
    chk("mr_busy", busy, 1'b0);
    chk("mr_flag", valid_hash_flag, 1'b0);
    step();
    n_rst = 1'b1;
    step();
    launch(32'h4000_0000, {32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 32'h4000_0000});
    core_done = 4'b1111;
    core_found = 4'b0010;
    set_res(1, R5);
    push(1'b1, R5);
    step();
    core_done = 4'b0000;
    core_found = 4'b0000;
    chk("mr_job_done", hash_done, 1'b1);
    chk("mr_job_hash", valid_hash, R5);
    step();
    chk("mr_job_idle", busy, 1'b0);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hash_core_dispatcher.md
# hash_core_dispatcher

Multi-core job dispatcher between the main controller and a parametrised array of SHA-256 hash cores. It partitions each job's nonce space into equal disjoint ranges, launches all cores together, and collects their done/found reports. It selects a single winner, quits the remaining cores, and returns one hash_done / valid_hash_flag / valid_hash result to the controller. It replaces the single-core hash manager hookup in the miner top level, adding core-count scaling, wrap-around nonce partitioning and abort handling.

## Interface
Parameters:
- NUM_CORES, 4, number of hash cores; power of two, 1..16
- NONCE_W, 32, nonce width in bits
- HASH_W, 256, hash digest width in bits

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset; one clock, reset is asynchronous and active-low
- begin_hash  in  1  one-cycle job start pulse from controller
- quit_hash  in  1  one-cycle abort pulse from controller
- base_nonce  in  NONCE_W  starting nonce of the job, sampled with begin_hash
- core_start  out  NUM_CORES  one-cycle per-core start pulse
- core_nonce_base  out  NUM_CORES*NONCE_W  per-core start nonce; core i occupies slice i
- core_quit  out  NUM_CORES  per-core quit level
- core_done  in  NUM_CORES  per-core one-cycle completion pulse (range exhausted, found, or quit acknowledged)
- core_found  in  NUM_CORES  qualifies core_done; valid result on core_result
- core_result  in  NUM_CORES*(HASH_W+NONCE_W)  per-core {hash, nonce}
- hash_done  out  1  one-cycle job-complete pulse
- valid_hash_flag  out  1  high with hash_done when a winner exists
- valid_hash  out  HASH_W+NONCE_W  registered winning {hash, nonce}; held until next job
- busy  out  1  high in every state except IDLE

## Operation
- RANGE = 2^(NONCE_W - log2(NUM_CORES)). Core i base = base_nonce + i*RANGE, modulo 2^NONCE_W (wraps silently).
- FSM states: IDLE, LAUNCH, RUN, DRAIN, REPORT.
- IDLE: on begin_hash, latch base_nonce, clear done_mask, winner and abort flags, then go to LAUNCH. begin_hash outside IDLE is ignored.
- LAUNCH: core_start is all ones for exactly one cycle; core_nonce_base is valid and held stable until the next job; go to RUN.
- RUN: core_done bits OR into done_mask.
  - If any core_done & core_found: capture the lowest-index such core's result as winner, then go to DRAIN.
  - Else if done_mask is all ones: go to REPORT.
- quit_hash in LAUNCH or RUN sets the abort flag and goes to DRAIN. quit_hash in DRAIN, REPORT or IDLE is ignored.
- DRAIN: core_quit is asserted on every core whose done_mask bit is clear. Keep accumulating core_done; found results in DRAIN are discarded. When done_mask is all ones: go to REPORT if not aborted, else IDLE.
- REPORT: hash_done=1 for one cycle; valid_hash_flag = winner flag; go to IDLE.
- Same-cycle found plus quit_hash in RUN: found wins, the result is captured, and the job is not aborted.
- Aborted jobs never pulse hash_done.
- Reset, including mid-job: state IDLE. All outputs are 0 (core_nonce_base 0, valid_hash 0, core_quit 0).

## Timing
- begin_hash at cycle t -> core_start at t+1 -> busy high from t+1.
- A found pulse at cycle t captures valid_hash at t+1. core_quit is high from t+1 until each core's done arrives.
- Last required core_done at t -> hash_done at t+1 (via REPORT). busy falls at t+2.
- Minimum job latency is begin_hash to hash_done = 3 cycles + core latency.
- All outputs are registered; no combinational path exists from core inputs to outputs.

## Structure
- Package miner_pkg: the dispatcher state enum, HASH_W/NONCE_W defaults, and the RESULT_W = HASH_W+NONCE_W constant.
- Sub-module core_winner_select: parametrised lowest-index priority encoder over core_done & core_found. It outputs an any-found flag and the winner index; the dispatcher muxes core_result using that index.

## Test plan
- NUM_CORES=4, base 0xF000_0000:
  - core_nonce_base = F0000000, 30000000, 70000000, B0000000.
  - core_start = 4'b1111 for exactly one cycle at t+1.
- Core 2 found with nonce 0x7000_0123:
  - valid_hash captured one cycle later; core_quit = 4'b1011.
  - After the other cores' done: hash_done=1, valid_hash_flag=1, valid_hash nonce = 0x7000_0123.
- Cores 1 and 3 found in the same cycle: core 1's result wins; core 3's later report is ignored.
- All four cores done, none found: hash_done=1 and valid_hash_flag=0 one cycle after the last done; valid_hash is unchanged.
- quit_hash in RUN with cores 0-1 already done:
  - core_quit = 4'b1100.
  - After cores 2-3 done: return to IDLE with no hash_done pulse.
  - A begin_hash issued during DRAIN is ignored.
- n_rst asserted mid-RUN: all outputs are 0 immediately and state is IDLE; a subsequent job runs normally.
